ee354_numlock_param: RTL and testbench
======================================

// Module: ee354_numlock_param
// PURPOSE
//  Parametrised successor of the U/Z push-button combination lock SM. Accepts a CODE_LEN-bit code entered as
//  U (=1) / Z (=0) presses, grants an unlock window of OPEN_CYCLES, counts failed attempts, and enters a
//  timed LOCKOUT after MAX_TRIES consecutive failures. Sits between debounced/slow-clocked buttons and top-level LED/SSD logic.
// PARAMETERS
//  CODE_LEN        4        number of digits in the code (1..15)
//  CODE            4'b1011  reset/default code, MSB entered first
//  MAX_TRIES       3        consecutive BAD entries before LOCKOUT (1..15)
//  OPEN_CYCLES     8        clk cycles unlock stays high (>=1)
//  LOCKOUT_CYCLES  16       clk cycles spent in LOCKOUT (>=1)
// PORTS
//  clk          in   1         system clock (divided clock in top level)
//  reset        in   1         asynchronous, active-high reset
//  U            in   1         "one" button, level (held = 1)
//  Z            in   1         "zero" button, level (held = 1)
//  load_code    in   1         code-program strobe (NUMLOCK_PROG_EN only, else ignored)
//  new_code     in   CODE_LEN  code to load on load_code (NUMLOCK_PROG_EN only)
//  unlock       out  1         high while in OPEN
//  bad          out  1         high while in BAD
//  locked_out   out  1         high while in LOCKOUT
//  state_num    out  3         IDLE=0 HELD=1 OPEN=2 BAD=3 LOCKOUT=4
//  digit_idx    out  4         digits accepted so far in current attempt
//  fail_cnt     out  4         consecutive failed attempts
// BEHAVIOUR
//  - One clock, one always-block state register; reset is asynchronous and active-high.
//  - Reset: state=IDLE, all outputs 0, digit_idx=0, fail_cnt=0, match flag=1, timer=0, code reg=CODE.
//  - All outputs are registered or decoded from registered state; no combinational path from U/Z to outputs.
//  - IDLE: U&Z -> BAD. U^Z -> HELD, latching digit=U and match &= (digit == code[CODE_LEN-1-digit_idx]).
//    Otherwise stay.
//  - HELD: waits for release. U&Z seen at any cycle -> BAD. Release (U=0,Z=0): digit_idx+1.
//    If new digit_idx==CODE_LEN: match ? OPEN : BAD. Else -> IDLE.
//    A wrong digit does not abort early; the full code is always taken before verdict.
//  - OPEN: unlock=1; timer loads OPEN_CYCLES-1 on entry, decrements; at 0 -> IDLE.
//    Entry clears fail_cnt, digit_idx, and sets match=1. U/Z ignored.
//  - BAD: on entry fail_cnt+1, saturating at 15; digit_idx=0, match=1.
//    Leave only when U=0 and Z=0: fail_cnt>=MAX_TRIES ? LOCKOUT : IDLE.
//  - LOCKOUT: locked_out=1; timer loads LOCKOUT_CYCLES-1 on entry; at 0 -> IDLE, fail_cnt=0. U/Z ignored.
//  - Unlock lasts exactly OPEN_CYCLES cycles. LOCKOUT lasts exactly LOCKOUT_CYCLES cycles.
//  - Reset mid-operation (any state) returns to the reset values immediately; the code register returns to CODE.
//  - Timer width is $clog2(max(OPEN_CYCLES,LOCKOUT_CYCLES)+1). No wrap: a count of 0 forces the exit transition.
// CONFIGURATION
//  NUMLOCK_PROG_EN defined:
//   - load_code sampled only in OPEN; code reg <= new_code on that cycle.
//   - The OPEN window is not extended. The new code takes effect from the next attempt.
//   - load_code outside OPEN is ignored.
//  NUMLOCK_PROG_EN undefined:
//   - Code reg is the constant CODE. load_code and new_code are unused.
//   - Behaviour is otherwise identical.
// TESTING
//  1. Default params, reset, press/release U,Z,U,U -> OPEN; unlock=1 for exactly 8 cycles, then state_num=0.
//  2. Enter U,U,U,U -> BAD on final release; bad=1, fail_cnt=1, then IDLE after both buttons released.
//  3. Three wrong 4-digit codes -> LOCKOUT with locked_out=1 for 16 cycles.
//     U/Z presses during LOCKOUT have no effect; exits with fail_cnt=0.
//  4. Press U and Z together mid-code (digit_idx=2) -> BAD next cycle; digit_idx=0; held until both released.
//  5. Assert reset while in OPEN at timer=3 -> unlock=0, state_num=0, fail_cnt=0 with no clock edge.
//  6. NUMLOCK_PROG_EN: in OPEN pulse load_code with new_code=4'b0110.
//     Next attempt U,Z,U,U -> BAD; Z,U,U,Z -> OPEN.

Source files
------------

// File: rtl/ee354_numlock_param.sv
// ee354_numlock_param: U/Z push-button combination lock with an unlock window,
// a failed-attempt counter and a timed lockout.
// Optional feature: define NUMLOCK_PROG_EN to allow reprogramming the code
// while the lock is open (load_code/new_code). Otherwise the code is the constant CODE.
//
// state   | meaning
// IDLE    | waiting for the next digit press
// HELD    | a digit button is held, waiting for release
// OPEN    | correct code entered, unlock window running
// BAD     | wrong code or both buttons pressed, waiting for release
// LOCKOUT | too many consecutive failures, timed lockout running
module ee354_numlock_param #(
  parameter int                  CODE_LEN       = 4,
  parameter logic [CODE_LEN-1:0] CODE           = 4'b1011,
  parameter int                  MAX_TRIES      = 3,
  parameter int                  OPEN_CYCLES    = 8,
  parameter int                  LOCKOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                U,
  input  logic                Z,
  input  logic                load_code,
  input  logic [CODE_LEN-1:0] new_code,
  output logic                unlock,
  output logic                bad,
  output logic                locked_out,
  output logic [2:0]          state_num,
  output logic [3:0]          digit_idx,
  output logic [3:0]          fail_cnt
);

  localparam int TMAX = (OPEN_CYCLES > LOCKOUT_CYCLES) ? OPEN_CYCLES : LOCKOUT_CYCLES;
  localparam int TW   = $clog2(TMAX + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_HELD    = 3'd1,
    S_OPEN    = 3'd2,
    S_BAD     = 3'd3,
    S_LOCKOUT = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic [3:0]    idx_q, idx_d;
  logic [3:0]    fail_q, fail_d;
  logic          match_q, match_d;
  logic [TW-1:0] timer_q, timer_d;

  logic [CODE_LEN-1:0] code_cur;
  logic [CODE_LEN-1:0] code_shift;
  logic                code_bit;
  logic [3:0]          idx_inc;
  logic [3:0]          fail_inc;
  logic                enter_bad;
  logic                enter_open;

`ifdef NUMLOCK_PROG_EN
  logic [CODE_LEN-1:0] code_q;

  // Code register: reloadable only while open; takes effect on the next attempt.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      code_q <= CODE;
    end else if (state_q == S_OPEN && load_code) begin
      code_q <= new_code;
    end
  end

  assign code_cur = code_q;
`else
  logic unused_prog;

  assign code_cur    = CODE;
  assign unused_prog = ^{load_code, new_code};
`endif

  // Digits are entered MSB first, so digit n compares against bit CODE_LEN-1-n.
  assign code_shift = code_cur >> (4'(CODE_LEN - 1) - idx_q);
  assign code_bit   = code_shift[0];
  assign idx_inc    = idx_q + 4'd1;
  assign fail_inc   = (fail_q == 4'hF) ? fail_q : fail_q + 4'd1;

  // State and datapath registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      fail_q  <= '0;
      match_q <= 1'b1;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      match_q <= match_d;
      timer_q <= timer_d;
    end
  end

  // Next-state logic; entry actions for BAD and OPEN are shared via flags.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    fail_d     = fail_q;
    match_d    = match_q;
    timer_d    = timer_q;
    enter_bad  = 1'b0;
    enter_open = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (U && Z) begin
          enter_bad = 1'b1;
        end else if (U ^ Z) begin
          state_d = S_HELD;
          match_d = match_q & (U == code_bit);
        end
      end
      S_HELD: begin
        if (U && Z) begin
          enter_bad = 1'b1;
        end else if (!U && !Z) begin
          // The full code is always taken before a verdict is given.
          if (idx_inc == 4'(CODE_LEN)) begin
            if (match_q) enter_open = 1'b1;
            else         enter_bad  = 1'b1;
          end else begin
            idx_d   = idx_inc;
            state_d = S_IDLE;
          end
        end
      end
      S_OPEN: begin
        if (timer_q == '0) state_d = S_IDLE;
        else               timer_d = timer_q - 1'b1;
      end
      S_BAD: begin
        if (!U && !Z) begin
          if (fail_q >= 4'(MAX_TRIES)) begin
            state_d = S_LOCKOUT;
            timer_d = TW'(LOCKOUT_CYCLES - 1);
          end else begin
            state_d = S_IDLE;
          end
        end
      end
      S_LOCKOUT: begin
        if (timer_q == '0) begin
          state_d = S_IDLE;
          fail_d  = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (enter_bad) begin
      state_d = S_BAD;
      fail_d  = fail_inc;
      idx_d   = '0;
      match_d = 1'b1;
    end
    if (enter_open) begin
      state_d = S_OPEN;
      fail_d  = '0;
      idx_d   = '0;
      match_d = 1'b1;
      timer_d = TW'(OPEN_CYCLES - 1);
    end
  end

  assign unlock     = (state_q == S_OPEN);
  assign bad        = (state_q == S_BAD);
  assign locked_out = (state_q == S_LOCKOUT);
  assign state_num  = state_q;
  assign digit_idx  = idx_q;
  assign fail_cnt   = fail_q;

endmodule

// File: tb/tb_ee354_numlock_param.sv
// Testbench for ee354_numlock_param (default parameters). Reference model keeps
// the current code, the failure count and the expected window lengths.
module tb_ee354_numlock_param;

  logic       clk = 1'b0;
  logic       reset;
  logic       U, Z;
  logic       load_code;
  logic [3:0] new_code;
  logic       unlock, bad, locked_out;
  logic [2:0] state_num;
  logic [3:0] digit_idx, fail_cnt;

  int         n_chk  = 0;
  int         n_fail = 0;
  int         fail_m = 0;
  logic [3:0] code_m = 4'b1011;
  bit         do_load = 1'b0;
  logic [3:0] load_val = 4'b0000;

  ee354_numlock_param dut (
    .clk(clk), .reset(reset), .U(U), .Z(Z),
    .load_code(load_code), .new_code(new_code),
    .unlock(unlock), .bad(bad), .locked_out(locked_out),
    .state_num(state_num), .digit_idx(digit_idx), .fail_cnt(fail_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic press(input logic d);
    U = d;
    Z = ~d;
    step();
    chk("held_state", state_num, 1);
    repeat ($urandom_range(0, 2)) step();
    U = 1'b0;
    Z = 1'b0;
    step();
  endtask

  task automatic run_open();
    int n = 0;
    while (unlock === 1'b1 && n < 40) begin
      if (do_load && n == 0) begin
        load_code = 1'b1;
        new_code  = load_val;
      end else begin
        load_code = 1'b0;
      end
      U = 1'($urandom_range(0, 1));
      Z = 1'($urandom_range(0, 1));
      n++;
      step();
    end
    load_code = 1'b0;
    U = 1'b0;
    Z = 1'b0;
    chk("open_len", n, 8);
    chk("open_exit_state", state_num, 0);
`ifdef NUMLOCK_PROG_EN
    if (do_load) code_m = load_val;
`endif
    do_load = 1'b0;
  endtask

  task automatic run_lockout();
    int n = 0;
    while (locked_out === 1'b1 && n < 60) begin
      U = 1'($urandom_range(0, 1));
      Z = 1'($urandom_range(0, 1));
      n++;
      step();
    end
    U = 1'b0;
    Z = 1'b0;
    fail_m = 0;
    chk("lockout_len", n, 16);
    chk("lockout_exit_state", state_num, 0);
    chk("lockout_exit_fail", fail_cnt, 0);
  endtask

  task automatic attempt(input logic [3:0] code);
    for (int i = 3; i >= 0; i--) begin
      press(code[i]);
      if (i > 0) chk("digit_idx", digit_idx, 4 - i);
    end
    if (code == code_m) begin
      fail_m = 0;
      chk("verdict_open", state_num, 2);
      chk("unlock", unlock, 1);
      chk("fail_clr", fail_cnt, 0);
      chk("idx_clr_open", digit_idx, 0);
      run_open();
    end else begin
      fail_m = (fail_m < 15) ? fail_m + 1 : 15;
      chk("verdict_bad", state_num, 3);
      chk("bad", bad, 1);
      chk("fail_cnt", fail_cnt, fail_m);
      chk("idx_clr_bad", digit_idx, 0);
      step();
      if (fail_m >= 3) begin
        chk("lockout_entry", locked_out, 1);
        run_lockout();
      end else begin
        chk("bad_exit", state_num, 0);
      end
    end
  endtask

  function automatic logic [3:0] wrong_code();
    logic [3:0] w;
    do w = 4'($urandom_range(0, 15)); while (w == code_m);
    return w;
  endfunction

  initial begin
    reset     = 1'b1;
    U         = 1'b0;
    Z         = 1'b0;
    load_code = 1'b0;
    new_code  = 4'b0000;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_state", state_num, 0);
    chk("rst_unlock", unlock, 0);
    chk("rst_bad", bad, 0);
    chk("rst_locked", locked_out, 0);
    chk("rst_idx", digit_idx, 0);
    chk("rst_fail", fail_cnt, 0);
    reset = 1'b0;
    step();

    // Correct code opens for exactly 8 cycles.
    attempt(4'b1011);
    // Wrong code, then two more wrong codes reach lockout.
    attempt(4'b1111);
    attempt(wrong_code());
    attempt(wrong_code());

    // Both buttons mid-code abort to BAD and hold there until released.
    press(1'b1);
    press(1'b0);
    chk("mid_idx", digit_idx, 2);
    U = 1'b1;
    Z = 1'b1;
    step();
    fail_m++;
    chk("uz_bad", state_num, 3);
    chk("uz_idx", digit_idx, 0);
    chk("uz_fail", fail_cnt, fail_m);
    repeat (3) begin
      Z = 1'($urandom_range(0, 1));
      step();
      chk("uz_hold", state_num, 3);
    end
    U = 1'b0;
    Z = 1'b0;
    step();
    chk("uz_exit", state_num, 0);

    // Random mix of correct and wrong attempts.
    for (int k = 0; k < 10; k++) begin
      if ($urandom_range(0, 2) == 0) attempt(code_m);
      else                           attempt(wrong_code());
    end

    // Asynchronous reset in OPEN with timer at 3.
    for (int i = 3; i >= 0; i--) press(code_m[i]);
    chk("pre_rst_open", state_num, 2);
    repeat (4) step();
    chk("pre_rst_still_open", unlock, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_unlock", unlock, 0);
    chk("async_rst_state", state_num, 0);
    chk("async_rst_fail", fail_cnt, 0);
    reset = 1'b0;
    step();

    // Asynchronous reset in BAD clears the failure count.
    for (int i = 3; i >= 0; i--) press(~code_m[i]);
    chk("pre_rst_bad", bad, 1);
    chk("pre_rst_fail", fail_cnt, 1);
    reset = 1'b1;
    #1;
    chk("async_rst_bad_fail", fail_cnt, 0);
    chk("async_rst_bad_state", state_num, 0);
    reset = 1'b0;
    fail_m = 0;
    code_m = 4'b1011;
    step();

`ifdef NUMLOCK_PROG_EN
    // load_code outside OPEN is ignored.
    load_code = 1'b1;
    new_code  = 4'b0001;
    step();
    load_code = 1'b0;
    attempt(4'b1011);
    // Reprogram while open.
    do_load  = 1'b1;
    load_val = 4'b0110;
    attempt(4'b1011);
    attempt(4'b1011);
    attempt(4'b0110);
    // Reset restores the default code.
    reset = 1'b1;
    #1;
    reset = 1'b0;
    code_m = 4'b1011;
    fail_m = 0;
    step();
    attempt(4'b0110);
    attempt(4'b1011);
`else
    // Without programming support load_code never changes the code.
    do_load  = 1'b1;
    load_val = 4'b0110;
    attempt(4'b1011);
    attempt(4'b0110);
    attempt(4'b1011);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
